// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches from inst_rom and queues {pc,inst} pairs for decode.
// Entry visible to decode one cycle after fetch; a full queue stalls fetch unless the head pops that same cycle.
module if_prefetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       rom_ce,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [INST_W-1:0]          rom_data,
   input  logic                       branch_flag,
   input  logic [ADDR_W-1:0]          branch_target,
   input  logic                       id_ready,
   output logic                       id_valid,
   output logic [ADDR_W-1:0]          id_pc,
   output logic [INST_W-1:0]          id_inst,
   output logic [$clog2(DEPTH):0]     q_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              push;
   logic              pop;

   assign rom_addr = pc;
   assign q_count  = count;
   assign id_valid = (count != '0);
   assign id_pc    = id_valid ? pc_mem[rd_ptr]   : '0;
   assign id_inst  = id_valid ? inst_mem[rd_ptr] : '0;

   assign pop  = id_valid && id_ready && !branch_flag;
   assign push = rom_ce && !branch_flag && ((count < FULL) || pop);

   // A redirect flushes everything and restarts fetch at the word-aligned target.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= '0;
         rom_ce <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (branch_flag) begin
         rom_ce <= 1'b1;
         pc     <= branch_target & ~ADDR_W'(3);
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rom_ce <= 1'b1;
         if (push) begin
            pc_mem[wr_ptr]   <= pc;
            inst_mem[wr_ptr] <= rom_data;
            wr_ptr           <= wr_ptr + 1'b1;
            pc               <= pc + ADDR_W'(4);
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a combinational ROM model (inst = addr ^ constant).
module tb_if_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [2:0]  q_count;

   int checks = 0;
   int errors = 0;

   if_prefetch_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
      .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
      .branch_flag(branch_flag), .branch_target(branch_target), .id_ready(id_ready),
      .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .q_count(q_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   assign rom_data = inst_of(rom_addr);

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      branch_flag = 1'b0;
      branch_target = '0;
      id_ready = 1'b0;
      step(3);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (rom_ce !== 1'b0 || id_valid !== 1'b0 || q_count !== 3'd0 || rom_addr !== 32'h0 ||
          id_pc !== 32'h0 || id_inst !== 32'h0) begin
         errors++;
         $display("FAIL reset: ce=%b vld=%b cnt=%0d addr=%h pc=%h inst=%h, want all zero",
                  rom_ce, id_valid, q_count, rom_addr, id_pc, id_inst);
      end
   endtask

   task automatic test_stream();
      id_ready = 1'b1;
      step(1);
      checks++;
      if (rom_ce !== 1'b1 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_e0: ce=%b vld=%b, want ce=1 vld=0", rom_ce, id_valid);
      end
      for (int i = 0; i < 6; i++) begin
         step(1);
         checks++;
         if (id_valid !== 1'b1 || id_pc !== 32'(i * 4) || id_inst !== inst_of(32'(i * 4)) ||
             q_count > 3'd1) begin
            errors++;
            $display("FAIL stream_%0d: vld=%b pc=%h inst=%h cnt=%0d, want vld=1 pc=%h cnt<=1",
                     i, id_valid, id_pc, id_inst, q_count, 32'(i * 4));
         end
      end
   endtask

   task automatic test_stall_full();
      do_reset();
      step(10);
      checks++;
      if (q_count !== 3'd4 || rom_addr !== 32'h10 || id_pc !== 32'h0) begin
         errors++;
         $display("FAIL stall_sat: cnt=%0d addr=%h head=%h, want cnt=4 addr=10 head=0",
                  q_count, rom_addr, id_pc);
      end
      id_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         checks++;
         if (id_pc !== 32'(i * 4) || id_inst !== inst_of(32'(i * 4)) || q_count !== 3'd4) begin
            errors++;
            $display("FAIL full_pushpop_%0d: pc=%h inst=%h cnt=%0d, want pc=%h cnt=4",
                     i, id_pc, id_inst, q_count, 32'(i * 4));
         end
      end
   endtask

   task automatic test_branch();
      do_reset();
      step(4);
      checks++;
      if (q_count !== 3'd3) begin
         errors++;
         $display("FAIL branch_pre: cnt=%0d, want 3", q_count);
      end
      branch_flag = 1'b1;
      branch_target = 32'h103;
      step(1);
      branch_flag = 1'b0;
      checks++;
      if (q_count !== 3'd0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 ||
          rom_addr !== 32'h100) begin
         errors++;
         $display("FAIL branch_flush: cnt=%0d vld=%b pc=%h inst=%h addr=%h, want 0/0/0/0/100",
                  q_count, id_valid, id_pc, id_inst, rom_addr);
      end
      step(1);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== inst_of(32'h100)) begin
         errors++;
         $display("FAIL branch_target: vld=%b pc=%h inst=%h, want vld=1 pc=100", id_valid, id_pc, id_inst);
      end
   endtask

   task automatic test_back_to_back();
      id_ready = 1'b1;
      branch_flag = 1'b1;
      branch_target = 32'h200;
      step(1);
      branch_target = 32'h300;
      step(1);
      branch_flag = 1'b0;
      checks++;
      if (rom_addr !== 32'h300 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_addr: addr=%h vld=%b, want addr=300 vld=0", rom_addr, id_valid);
      end
      step(1);
      checks++;
      if (id_pc !== 32'h300 || id_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_head: pc=%h vld=%b, want pc=300 vld=1", id_pc, id_valid);
      end
   endtask

   task automatic test_wrap();
      id_ready = 1'b0;
      branch_flag = 1'b1;
      branch_target = 32'hFFFF_FFFF;
      step(1);
      branch_flag = 1'b0;
      checks++;
      if (rom_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_target: addr=%h, want fffffffc", rom_addr);
      end
      step(1);
      checks++;
      if (id_pc !== 32'hFFFF_FFFC || rom_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pc: head=%h addr=%h, want fffffffc/0", id_pc, rom_addr);
      end
      id_ready = 1'b1;
      step(1);
      checks++;
      if (id_pc !== 32'h0 || id_inst !== inst_of(32'h0) || q_count !== 3'd1) begin
         errors++;
         $display("FAIL wrap_next: head=%h inst=%h cnt=%0d, want 0 cnt=1", id_pc, id_inst, q_count);
      end
   endtask

   task automatic test_reset_mid();
      id_ready = 1'b0;
      step(6);
      checks++;
      if (q_count !== 3'd4) begin
         errors++;
         $display("FAIL rst_mid_full: cnt=%0d, want 4", q_count);
      end
      rst = 1'b1;
      branch_flag = 1'b1;
      branch_target = 32'h40;
      step(1);
      checks++;
      if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || q_count !== 3'd0 || id_valid !== 1'b0 ||
          id_pc !== 32'h0 || id_inst !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid: ce=%b addr=%h cnt=%0d vld=%b pc=%h inst=%h, want all zero",
                  rom_ce, rom_addr, q_count, id_valid, id_pc, id_inst);
      end
      rst = 1'b0;
      branch_flag = 1'b0;
      step(2);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_restart: vld=%b pc=%h, want vld=1 pc=0", id_valid, id_pc);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_full();
      test_branch();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
